// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect handling and a one-entry
// instruction buffer in front of decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic [31:0] pc
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INSTR_SZ = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            if_valid_q, if_valid_d;
  logic            pend_q, pend_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_tgt;
  logic            imem_req_c;
  logic            ack_take;

  // Redirect arbitration: exception over jump over branch, word aligned.
  always_comb begin
    redirect     = exc | jump | branch_taken;
    redirect_tgt = branch_target;
    if (exc) begin
      redirect_tgt = EXC_VECTOR;
    end else if (jump) begin
      redirect_tgt = jump_target;
    end
    redirect_tgt = redirect_tgt & ~XLEN'(3);
  end

  // A request, once raised, is held via pend_q until the memory acknowledges.
  always_comb begin
    imem_req_c = 1'b0;
    unique case (state_q)
      S_REQ:   imem_req_c = pend_q | ~if_valid_q | id_ready;
      S_DROP:  imem_req_c = 1'b1;
      default: imem_req_c = 1'b0;
    endcase
  end

  assign ack_take  = imem_req_c & imem_ack;
  assign imem_req  = imem_req_c;
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign pc        = pc_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;
    pend_d      = pend_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) begin
          pc_d = redirect_tgt;
        end
      end

      S_REQ: begin
        if (redirect) begin
          pc_d       = redirect_tgt;
          if_valid_d = 1'b0;
          pend_d     = 1'b0;
          // Memory has seen the old address; wait out its ack before refetching.
          if (imem_req_c && !imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (ack_take) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + XLEN'(INSTR_SZ);
          pend_d     = 1'b0;
        end else begin
          pend_d = imem_req_c;
          if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
          end
        end
      end

      S_DROP: begin
        if (redirect) begin
          pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      if_instr_q  <= '0;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0080, the fetch address loaded on an exception.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 exc  in  1  exception redirect request.
REQ-006 jump  in  1  jump redirect request.
REQ-007 jump_target  in  32  jump destination.
REQ-008 branch_taken  in  1  branch redirect request.
REQ-009 branch_target  in  32  branch destination.
REQ-010 imem_req  out  1  instruction-memory read request.
REQ-011 imem_addr  out  32  read address; always equal to pc while imem_req=1 in S_REQ.
REQ-012 imem_ack  in  1  read completion; imem_rdata valid in the same cycle.
REQ-013 imem_rdata  in  32  returned instruction.
REQ-014 if_valid  out  1  instruction buffer holds a valid instruction for decode.
REQ-015 if_instr  out  32  buffered instruction.
REQ-016 if_pc  out  32  address of the buffered instruction.
REQ-017 id_ready  in  1  decode accepts if_instr when if_valid=1 and id_ready=1.
REQ-018 pc  out  32  address of the next instruction to fetch.

Function
REQ-019 The FSM SHALL have the states S_IDLE, S_REQ and S_DROP.
REQ-020 S_IDLE SHALL last exactly one cycle after reset release, with imem_req=0, and then go to S_REQ.
REQ-021 In S_REQ, imem_req SHALL be 1 when if_valid=0 or id_ready=1; otherwise imem_req SHALL be 0 and the state SHALL hold.
REQ-022 Once imem_req=1, imem_req and imem_addr SHALL remain stable until the cycle in which imem_ack=1.
REQ-023 On imem_ack in S_REQ with no redirect, if_instr<=imem_rdata, if_pc<=pc, if_valid<=1 and pc<=pc+4 on the same edge; minimum fetch latency is 1 cycle from ack to if_valid.
REQ-024 The pc+4 sum SHALL wrap modulo 2^32, so 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-025 Redirect priority SHALL be exc > jump > branch_taken > sequential; the target is EXC_VECTOR, jump_target or branch_target respectively.
REQ-026 All redirect targets SHALL be loaded into pc with bits [1:0] forced to 2'b00.
REQ-027 On any redirect cycle, pc<=target and if_valid<=0 on the next edge; an imem_ack in that same cycle SHALL be discarded.
REQ-028 A redirect while imem_req=1 and imem_ack=0 SHALL move the FSM to S_DROP.
REQ-029 S_DROP SHALL keep imem_req=1 with the old address until imem_ack, discard that data, then return to S_REQ.
REQ-030 A further redirect in S_DROP SHALL update pc only (latest/highest-priority wins) and SHALL NOT re-enter the state.
REQ-031 if_valid SHALL clear on consumption (if_valid and id_ready) unless a new ack loads the buffer in the same cycle.
REQ-032 A buffer load and consumption in the same cycle SHALL leave if_valid=1 holding the new instruction.
REQ-033 While if_valid=1 and id_ready=0, if_instr and if_pc SHALL be held unchanged.

Reset
REQ-034 While rst=0, regardless of clk: state=S_IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
REQ-035 Reset asserted mid-request SHALL abandon the outstanding request; an imem_ack arriving after reset release and before the first new request SHALL be ignored.

Verification
REQ-036 Release reset with imem_ack one cycle after each req and id_ready=1 -> addresses 0x0, 0x4, 0x8 issued in order, with if_pc matching each if_instr.
REQ-037 Hold id_ready=0 with the buffer full -> imem_req=0 and if_instr stable; raise id_ready -> the next fetch issues the following cycle.
REQ-038 Assert jump (jump_target=0x103) and branch_taken together with the ack -> pc=0x100, ack data dropped, if_valid=0, next imem_addr=0x100.
REQ-039 Assert exc while a request is outstanding with a 3-cycle ack delay -> S_DROP, old address held until ack, data discarded, then fetch from 0x80.
REQ-040 Set pc=0xFFFF_FFFC via branch and ack the fetch -> pc wraps to 0x0.
REQ-041 Pull rst low mid-request, then release -> all outputs at their reset values and the first fetch is from RESET_PC.
